sd_photo_loader: RTL and testbench

SD_PHOTO_LOADER -- requirements
Module: sd_photo_loader

---
 rtl/sd_photo_loader_pkg.sv | 36 +++
 rtl/sd_photo_loader_bgr_to_rgb565.sv | 88 ++++++++
 rtl/sd_photo_loader.sv | 108 ++++++++++
 tb/tb_sd_photo_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_photo_loader_pkg.sv
// Shared definitions for the SD photo loader: FSM states, BMP header size
// and RGB565 field layout.
package sd_photo_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    // 54-byte BMP header expressed in 16-bit stream words
    localparam int BMP_HDR_WORDS = 27;

    // RGB565 field positions and widths
    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;

    // Keep the top bits of each 8-bit channel
    function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        p[R_LSB +: R_W] = r[7 -: R_W];
        p[G_LSB +: G_W] = g[7 -: G_W];
        p[B_LSB +: B_W] = b[7 -: B_W];
        return p;
    endfunction

endpackage

// File: rtl/sd_photo_loader_bgr_to_rgb565.sv
// Skips the BMP header, repacks the 3-word BGR byte stream into RGB565
// pixels and stops writing once the pixel budget is reached.
module bgr_to_rgb565
    import sd_photo_loader_pkg::*;
#(
    parameter int HDR_WORDS = BMP_HDR_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [15:0] data,
    input  logic [23:0] max_pix,
    output logic        wr_en,
    output logic [15:0] wr_data
);

    logic [15:0] word_cnt;
    logic [1:0]  phase;
    logic [7:0]  b0;
    logic [7:0]  g0;
    logic [7:0]  b1;
    logic [23:0] pix_cnt;
    logic        in_hdr;
    logic        room;
    logic [15:0] pix_next;

    assign in_hdr = word_cnt < 16'(HDR_WORDS);
    assign room   = pix_cnt != max_pix;

    // Pixel completed by the word currently on the bus (phase 1 or 2)
    always_comb begin
        pix_next = '0;
        case (phase)
            2'd1:    pix_next = pack_rgb565(data[15:8], g0, b0);
            2'd2:    pix_next = pack_rgb565(data[7:0], data[15:8], b1);
            default: pix_next = '0;
        endcase
    end

    // Header skip, byte staging and registered pixel write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            phase    <= '0;
            b0       <= '0;
            g0       <= '0;
            b1       <= '0;
            pix_cnt  <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                word_cnt <= '0;
                phase    <= '0;
                pix_cnt  <= '0;
            end else if (accept) begin
                if (in_hdr) begin
                    word_cnt <= word_cnt + 16'd1;
                end else begin
                    case (phase)
                        2'd0: begin
                            b0    <= data[15:8];
                            g0    <= data[7:0];
                            phase <= 2'd1;
                        end
                        2'd1, 2'd2: begin
                            if (phase == 2'd1) begin
                                b1    <= data[7:0];
                                phase <= 2'd2;
                            end else begin
                                phase <= 2'd0;
                            end
                            if (room) begin
                                wr_en   <= 1'b1;
                                wr_data <= pix_next;
                                pix_cnt <= pix_cnt + 24'd1;
                            end
                        end
                        default: phase <= 2'd0;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sd_photo_loader.sv
// Loads one BMP picture from SD: requests consecutive sectors and streams
// the converted RGB565 pixels towards SDRAM.
module sd_photo_loader
    import sd_photo_loader_pkg::*;
#(
    parameter int HDR_WORDS = BMP_HDR_WORDS,
    parameter int SEC_AW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEC_AW-1:0] pic_sec_addr,
    input  logic [15:0]       sd_sec_num,
    input  logic [23:0]       sdram_max_addr,
    input  logic              sd_init_done,
    input  logic              rd_busy,
    input  logic              rd_val_en,
    input  logic [15:0]       rd_val_data,
    output logic              rd_start_en,
    output logic [SEC_AW-1:0] rd_sec_addr,
    output logic              sdram_wr_en,
    output logic [15:0]       sdram_wr_data,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [SEC_AW-1:0] base;
    logic [15:0]       sec_num;
    logic [15:0]       sec_cnt;
    logic [15:0]       sec_cnt_inc;
    logic [23:0]       max_pix;
    logic              start_ok;
    logic              accept;

    assign start_ok    = (state == IDLE) && start && sd_init_done;
    assign accept      = rd_val_en && ((state == WAIT_HI) || (state == WAIT_LO));
    assign sec_cnt_inc = sec_cnt + 16'd1;

    // Sector sequencing FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_start_en <= 1'b0;
            rd_sec_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            base        <= '0;
            sec_num     <= '0;
            sec_cnt     <= '0;
            max_pix     <= '0;
        end else begin
            rd_start_en <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        base    <= pic_sec_addr;
                        sec_num <= sd_sec_num;
                        max_pix <= sdram_max_addr;
                        sec_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= (sd_sec_num == 16'd0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (!rd_busy) begin
                        rd_start_en <= 1'b1;
                        rd_sec_addr <= base + SEC_AW'(sec_cnt);
                        state       <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (rd_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!rd_busy) begin
                        sec_cnt <= sec_cnt_inc;
                        state   <= (sec_cnt_inc == sec_num) ? DONE : REQ;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    bgr_to_rgb565 #(
        .HDR_WORDS(HDR_WORDS)
    ) u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .accept  (accept),
        .data    (rd_val_data),
        .max_pix (max_pix),
        .wr_en   (sdram_wr_en),
        .wr_data (sdram_wr_data)
    );

endmodule

// File: tb/tb_sd_photo_loader.sv
// Scoreboard bench for sd_photo_loader: directed loads with an SD read model,
// expected sector addresses and pixels queued ahead, checked by a monitor.
module tb_sd_photo_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] pic_sec_addr;
    logic [15:0] sd_sec_num;
    logic [23:0] sdram_max_addr;
    logic        sd_init_done;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        sdram_wr_en;
    logic [15:0] sdram_wr_data;
    logic        busy;
    logic        done;

    int n_vec;
    int n_miss;
    int done_cnt;
    logic [31:0] exp_addr[$];
    logic [15:0] exp_pix[$];

    // Pixel words sent right after the header, and the hand-computed pixels
    logic [15:0] tbl_words[15] = '{
        16'hF8FC, 16'hF800, 16'h0000,
        16'h0000, 16'h00F8, 16'hFCF8,
        16'h0000, 16'hF800, 16'hFC00,
        16'hF800, 16'h00F8, 16'h0000,
        16'h1008, 16'h4020, 16'h0804
    };
    logic [15:0] tbl_pix[10] = '{
        16'hFFFF, 16'h0000,
        16'h0000, 16'hFFFF,
        16'hF800, 16'h07E0,
        16'h001F, 16'h001F,
        16'h4042, 16'h0044
    };

    sd_photo_loader #(
        .HDR_WORDS(27),
        .SEC_AW   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pic_sec_addr   (pic_sec_addr),
        .sd_sec_num     (sd_sec_num),
        .sdram_max_addr (sdram_max_addr),
        .sd_init_done   (sd_init_done),
        .rd_busy        (rd_busy),
        .rd_val_en      (rd_val_en),
        .rd_val_data    (rd_val_data),
        .rd_start_en    (rd_start_en),
        .rd_sec_addr    (rd_sec_addr),
        .sdram_wr_en    (sdram_wr_en),
        .sdram_wr_data  (sdram_wr_data),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %h expected no event", name, act);
    endtask

    // Monitor: pop and compare whenever the DUT presents a request or a pixel
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_start_en) begin
                if (exp_addr.size() == 0) flag("unexpected rd_start_en", rd_sec_addr);
                else check("rd_sec_addr", rd_sec_addr, exp_addr.pop_front());
            end
            if (sdram_wr_en) begin
                if (exp_pix.size() == 0) flag("unexpected sdram_wr_en", {16'h0, sdram_wr_data});
                else check("sdram_wr_data", {16'h0, sdram_wr_data}, {16'h0, exp_pix.pop_front()});
            end
            if (done) done_cnt++;
        end
    end

    function automatic logic [15:0] word_at(input int w);
        if (w < 27) return 16'hFFFF;
        if (w - 27 < 15) return tbl_words[w - 27];
        return 16'h0000;
    endfunction

    task automatic check_outputs_zero(input string name);
        check(name, {rd_start_en, sdram_wr_en, busy, done}, 32'h0);
        check({name, " addr"}, rd_sec_addr, 32'h0);
        check({name, " data"}, {16'h0, sdram_wr_data}, 32'h0);
    endtask

    // One picture load with the SD model; optional interfering start and reset abort
    task automatic do_load(input logic [31:0] base, input logic [15:0] nsec,
                           input logic [23:0] maxp, input int abort_sec, input bit poke);
        int w;
        int words;
        int npix;
        int d0;
        bit got;
        w = 0;
        words = int'(nsec) * 256 - 27;
        npix = (words / 3) * 2 + (((words % 3) == 2) ? 1 : 0);
        if (int'(maxp) < npix) npix = int'(maxp);
        for (int s = 0; s < int'(nsec); s++) exp_addr.push_back(base + 32'(s));
        for (int i = 0; i < npix; i++) exp_pix.push_back((i < 10) ? tbl_pix[i] : 16'h0000);
        d0 = done_cnt;
        @(negedge clk);
        pic_sec_addr = base;
        sd_sec_num = nsec;
        sdram_max_addr = maxp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pic_sec_addr = 32'h0000_0999;
        sd_sec_num = 16'd1;
        sdram_max_addr = 24'd2;
        for (int s = 0; s < int'(nsec); s++) begin
            got = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (rd_start_en) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) begin
                flag("rd_start_en timeout", 32'(s));
                return;
            end
            rd_busy = 1'b1;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (s == abort_sec && i == 100) begin
                    rst_n = 1'b0;
                    rd_busy = 1'b0;
                    rd_val_en = 1'b0;
                    #1;
                    check_outputs_zero("outputs in reset");
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (20) @(negedge clk);
                    check("no done after abort", 32'(done_cnt - d0), 32'd0);
                    check("idle after abort", {31'h0, busy}, 32'd0);
                    return;
                end
                rd_val_en = 1'b1;
                rd_val_data = word_at(w);
                w++;
                start = poke && s == 0 && i == 5;
            end
            @(negedge clk);
            rd_val_en = 1'b0;
            rd_busy = 1'b0;
        end
        for (int t = 0; t < 20; t++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("done pulses", 32'(done_cnt - d0), 32'd1);
        check("busy after load", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        n_vec = 0;
        n_miss = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        pic_sec_addr = '0;
        sd_sec_num = '0;
        sdram_max_addr = '0;
        sd_init_done = 1'b1;
        rd_busy = 1'b0;
        rd_val_en = 1'b0;
        rd_val_data = '0;
        #12;
        check_outputs_zero("reset state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two sectors from 0x100, 10 pixels, with a start pulse while busy
        do_load(32'h0000_0100, 16'd2, 24'd10, -1, 1'b1);
        // Pixel budget of 4 while both sectors are still read
        do_load(32'h0000_0040, 16'd2, 24'd4, -1, 1'b0);
        // No clipping; address add carries; packer phase must restart
        do_load(32'h0FFF_FFFF, 16'd2, 24'd1000, -1, 1'b0);

        // Stream words while idle: must not be consumed
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_val_en = 1'b1;
            rd_val_data = 16'hF8F8;
        end
        @(negedge clk);
        rd_val_en = 1'b0;

        // Zero sectors: done two cycles after start, no read request
        d0 = done_cnt;
        pic_sec_addr = 32'h0000_0500;
        sd_sec_num = 16'd0;
        sdram_max_addr = 24'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero-sector done early", {31'h0, done}, 32'd0);
        @(negedge clk);
        check("zero-sector done", {31'h0, done}, 32'd1);
        @(negedge clk);
        check("zero-sector done width", {31'h0, done}, 32'd0);
        check("zero-sector done count", 32'(done_cnt - d0), 32'd1);

        // Start without an initialised card is ignored
        sd_init_done = 1'b0;
        sd_sec_num = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("start without init", {31'h0, busy}, 32'd0);
        sd_init_done = 1'b1;

        // Reset during the second sector, then a normal load
        do_load(32'h0000_0200, 16'd2, 24'd0, 1, 1'b0);
        do_load(32'h0000_0300, 16'd2, 24'd10, -1, 1'b0);

        repeat (5) @(negedge clk);
        check("pending sector addresses", 32'(exp_addr.size()), 32'd0);
        check("pending pixels", 32'(exp_pix.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
